burst_mem_responder: RTL

Word-wide memory responder that serves 8-word cache-line bursts on the 32-bit memory side of the L1 cache's line adaptor. It accepts a line-aligned read or write request, waits a programmable access latency, then streams one 32-bit beat per cycle with `mem_valid`. It holds an internal word-addressed RAM with byte-strobed writes. It stands in for main memory in the multicycle OTTER cache build and its testbenches.

---
 rtl/burst_mem_responder_if.sv | 32 +++
 rtl/burst_mem_responder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/burst_mem_responder_if.sv
// Memory-side burst bus between a line adaptor (master) and the burst memory
// responder (slave). Requests are held for a whole transaction; beats are
// qualified by mem_valid.
interface burst_mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_strobe;
    logic        mem_valid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        output mem_strobe,
        input  mem_valid,
        input  mem_rdata
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        input  mem_strobe,
        output mem_valid,
        output mem_rdata
    );
endinterface

// File: rtl/burst_mem_responder.sv
// Burst memory responder: accepts a line-aligned read or write request, waits
// a fixed access latency, then streams BURST_LEN 32-bit beats, one per cycle.
// Backed by a word-addressed RAM with byte-strobed writes and registered reads.
module burst_mem_responder #(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    BURST_LEN   = 8,
    parameter int    LATENCY     = 4,
    parameter string INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    burst_mem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int BW = $clog2(BURST_LEN);
    localparam int LW = AW - BW;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [3:0]    LAT_LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAT,
        ST_BURST,
        ST_HOLD
    } state_t;

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic [BW-1:0] beat_reg, beat_next;
    logic [LW-1:0] line_reg, line_next;
    logic          dir_rd_reg, dir_rd_next;
    logic [31:0]   rdata_reg;

    logic [31:0]   ram [DEPTH_WORDS];

    logic          req_held;
    logic          ram_we;
    logic          rd_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          unused_addr_bits;

    // The request line that matters is the one for the latched direction.
    assign req_held = dir_rd_reg ? bus.mem_read : bus.mem_write;
    // The line index is latched, so beat offsets can never leave the line.
    assign wr_addr  = {line_reg, beat_reg};
    // Byte offset within the line and address bits above the RAM alias away.
    assign unused_addr_bits = ^{bus.mem_addr[31:2+AW], bus.mem_addr[1+BW:0]};

    assign bus.mem_valid = (state_reg == ST_BURST);
    assign bus.mem_rdata = rdata_reg;

    // Control and beat registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            beat_reg   <= '0;
            line_reg   <= '0;
            dir_rd_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            beat_reg   <= beat_next;
            line_reg   <= line_next;
            dir_rd_reg <= dir_rd_next;
        end
    end

    // Next-state logic and per-cycle RAM strobes.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        beat_next   = beat_reg;
        line_next   = line_reg;
        dir_rd_next = dir_rd_reg;
        ram_we      = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = {line_reg, beat_reg + BW'(1)};

        case (state_reg)
            ST_IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    state_next  = ST_LAT;
                    dir_rd_next = bus.mem_read;
                    line_next   = bus.mem_addr[2+BW +: LW];
                    cnt_next    = LAT_LOAD;
                end
            end
            ST_LAT: begin
                if (!req_held) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == 4'd0) begin
                    // Prefetch beat 0 so it is stable for its whole cycle.
                    state_next = ST_BURST;
                    beat_next  = '0;
                    rd_en      = dir_rd_reg;
                    rd_addr    = {line_reg, {BW{1'b0}}};
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_BURST: begin
                if (!req_held) begin
                    state_next = ST_IDLE;
                end else begin
                    ram_we    = !dir_rd_reg;
                    // Last beat does not prefetch, so rdata keeps its value.
                    rd_en     = dir_rd_reg && (beat_reg != LAST_BEAT);
                    beat_next = beat_reg + BW'(1);
                    if (beat_reg == LAST_BEAT) begin
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!bus.mem_read && !bus.mem_write) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Byte-strobed RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_strobe[b]) begin
                    ram[wr_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered RAM read; holds between bursts.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (rd_en) begin
            rdata_reg <= ram[rd_addr];
        end
    end
endmodule
